// File: rtl/vend_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_txn_ctrl
// Description : Vending-machine transaction controller (operation mode).
//               Validates a selection against the item configuration store,
//               collects coins until the cost is covered, dispenses and
//               commits the stock decrement, then pays change. Refunds the
//               balance on cancel, on entry to configuration mode, or on
//               timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   pclk, prst           clock, asynchronous active-high reset
//   cfg_mode             1 = configuration mode (no transactions)
//   num_items            number of valid item ids loaded
//   sel_valid, sel_id    item selection strobe and id
//   coin_valid/value     coin strobe and value in cents
//   coin_ready           coins are credited this cycle (COLLECT only)
//   cancel               user cancel / refund request
//   cfg_item_*           store read strobe, stock-decrement strobe, item id
//   item_cost/available  store data for cfg_item_id (combinational)
//   dispense_valid/id    one-cycle dispense pulse with item id
//   change_valid/value   change or refund amount, held until change_ack
//   err_valid/err_code   one-cycle error pulse: 0 bad id, 1 sold out,
//                        2 timeout refund
//   busy                 controller is not idle
// ============================================================================
module vend_txn_ctrl #(
  parameter int MAX_ITEMS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         pclk,
  input  logic                         prst,
  input  logic                         cfg_mode,
  input  logic [$clog2(MAX_ITEMS)-1:0] num_items,
  input  logic                         sel_valid,
  input  logic [$clog2(MAX_ITEMS)-1:0] sel_id,
  input  logic                         coin_valid,
  input  logic [15:0]                  coin_value,
  output logic                         coin_ready,
  input  logic                         cancel,
  output logic                         cfg_item_read_req,
  output logic                         cfg_item_update_req,
  output logic [$clog2(MAX_ITEMS)-1:0] cfg_item_id,
  input  logic [15:0]                  item_cost,
  input  logic [7:0]                   item_available,
  output logic                         dispense_valid,
  output logic [$clog2(MAX_ITEMS)-1:0] dispense_id,
  output logic                         change_valid,
  output logic [15:0]                  change_value,
  input  logic                         change_ack,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic                         busy
);

  localparam int ID_W  = $clog2(MAX_ITEMS);
  // +1 keeps the width non-zero for TIMEOUT_CYCLES == 1
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_BAD_ID   = 2'd0;
  localparam logic [1:0] ERR_SOLD_OUT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_COLLECT  = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_CHANGE   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   id_reg, id_n;
  logic [15:0]       cost_reg, cost_n;
  logic [15:0]       balance, balance_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [15:0]       change_reg, change_n;
  logic              err_v_reg, err_v_n;
  logic [1:0]        err_c_reg, err_c_n;

  logic [16:0]       coin_sum;
  logic [15:0]       coin_sat;
  logic              refund;

  // Saturating add of the incoming coin onto the registered balance
  assign coin_sum = {1'b0, balance} + {1'b0, coin_value};
  assign coin_sat = coin_sum[16] ? 16'hFFFF : coin_sum[15:0];

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state      <= ST_IDLE;
      id_reg     <= '0;
      cost_reg   <= '0;
      balance    <= '0;
      timer      <= '0;
      change_reg <= '0;
      err_v_reg  <= 1'b0;
      err_c_reg  <= 2'd0;
    end else begin
      state      <= state_n;
      id_reg     <= id_n;
      cost_reg   <= cost_n;
      balance    <= balance_n;
      timer      <= timer_n;
      change_reg <= change_n;
      err_v_reg  <= err_v_n;
      err_c_reg  <= err_c_n;
    end
  end

  always_comb begin
    state_n   = state;
    id_n      = id_reg;
    cost_n    = cost_reg;
    balance_n = balance;
    timer_n   = timer;
    change_n  = change_reg;
    err_v_n   = 1'b0;
    err_c_n   = err_c_reg;
    refund    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!cfg_mode && sel_valid) begin
          if (sel_id < num_items) begin
            id_n    = sel_id;
            state_n = ST_READ;
          end else begin
            err_v_n = 1'b1;
            err_c_n = ERR_BAD_ID;
          end
        end
      end

      ST_READ: begin
        if (item_available == 8'd0) begin
          err_v_n = 1'b1;
          err_c_n = ERR_SOLD_OUT;
          state_n = ST_IDLE;
        end else begin
          cost_n    = item_cost;
          timer_n   = '0;
          balance_n = '0;
          state_n   = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (coin_valid) begin
          balance_n = coin_sat;
          timer_n   = '0;
        end else begin
          timer_n   = timer + TMR_W'(1);
        end
        if (cancel || cfg_mode) begin
          refund = 1'b1;
        end else if (timer == TMR_LAST) begin
          refund  = 1'b1;
          err_v_n = 1'b1;
          err_c_n = ERR_TIMEOUT;
        end else if (balance >= cost_reg) begin
          // Decision uses the registered balance; a coin landing this cycle
          // is still credited and ends up in the change.
          state_n = ST_DISPENSE;
        end
        if (refund) begin
          // Refund includes any coin accepted this same cycle
          if (balance_n == 16'd0) begin
            state_n = ST_IDLE;
          end else begin
            change_n = balance_n;
            state_n  = ST_CHANGE;
          end
          balance_n = '0;
        end
      end

      ST_DISPENSE: begin
        change_n  = balance - cost_reg;
        balance_n = '0;
        state_n   = (balance != cost_reg) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        if (change_ack) begin
          change_n = '0;
          state_n  = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from state or taken straight from registers
  assign coin_ready          = (state == ST_COLLECT);
  assign cfg_item_read_req   = (state == ST_READ);
  assign cfg_item_update_req = (state == ST_DISPENSE);
  assign dispense_valid      = (state == ST_DISPENSE);
  assign change_valid        = (state == ST_CHANGE);
  assign busy                = (state != ST_IDLE);
  assign cfg_item_id         = id_reg;
  assign dispense_id         = id_reg;
  assign change_value        = change_reg;
  assign err_valid           = err_v_reg;
  assign err_code            = err_c_reg;

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_txn_ctrl
// Description : Directed self-checking bench for vend_txn_ctrl with a small
//               combinational item store model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_txn_ctrl;

  logic        pclk, prst, cfg_mode, sel_valid, coin_valid, cancel, change_ack;
  logic [9:0]  num_items, sel_id;
  logic [15:0] coin_value;
  logic        coin_ready, cfg_item_read_req, cfg_item_update_req;
  logic [9:0]  cfg_item_id, dispense_id;
  logic [15:0] item_cost, change_value;
  logic [7:0]  item_available;
  logic        dispense_valid, change_valid, err_valid, busy;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int disp_cnt = 0;

  logic [15:0] cost_mem  [0:7];
  logic [7:0]  avail_mem [0:7];

  vend_txn_ctrl #(.MAX_ITEMS(1024), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .prst(prst), .cfg_mode(cfg_mode), .num_items(num_items),
    .sel_valid(sel_valid), .sel_id(sel_id), .coin_valid(coin_valid),
    .coin_value(coin_value), .coin_ready(coin_ready), .cancel(cancel),
    .cfg_item_read_req(cfg_item_read_req), .cfg_item_update_req(cfg_item_update_req),
    .cfg_item_id(cfg_item_id), .item_cost(item_cost), .item_available(item_available),
    .dispense_valid(dispense_valid), .dispense_id(dispense_id),
    .change_valid(change_valid), .change_value(change_value), .change_ack(change_ack),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  assign item_cost      = (cfg_item_id < 10'd8) ? cost_mem[cfg_item_id[2:0]]  : 16'd0;
  assign item_available = (cfg_item_id < 10'd8) ? avail_mem[cfg_item_id[2:0]] : 8'd0;

  always @(posedge pclk) begin
    if (cfg_item_update_req) upd_cnt++;
    if (dispense_valid) disp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic select(input logic [9:0] id);
    sel_id = id; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0d want 0", busy); end
    checks++; if (coin_ready !== 1'b0) begin errors++; $display("FAIL rst_coin_ready got %0d want 0", coin_ready); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL rst_change_valid got %0d want 0", change_valid); end
    checks++; if (cfg_item_read_req !== 1'b0) begin errors++; $display("FAIL rst_read_req got %0d want 0", cfg_item_read_req); end
    checks++; if (change_value !== 16'd0) begin errors++; $display("FAIL rst_change_value got %0h want 0", change_value); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_err_valid got %0d want 0", err_valid); end
    step(); step();
    prst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %0d want 0", busy); end
  endtask

  task automatic test_purchase();
    int u0, d0;
    u0 = upd_cnt; d0 = disp_cnt;
    select(10'd3);
    checks++; if (cfg_item_read_req !== 1'b1) begin errors++; $display("FAIL t1_read_req got %0d want 1", cfg_item_read_req); end
    checks++; if (cfg_item_id !== 10'd3) begin errors++; $display("FAIL t1_item_id got %0d want 3", cfg_item_id); end
    step();
    checks++; if (coin_ready !== 1'b1) begin errors++; $display("FAIL t1_coin_ready got %0d want 1", coin_ready); end
    checks++; if (cfg_item_read_req !== 1'b0) begin errors++; $display("FAIL t1_read_req_pulse got %0d want 0", cfg_item_read_req); end
    coin_value = 16'd100; coin_valid = 1'b1;
    step();
    step();
    coin_valid = 1'b0;
    checks++; if (dispense_valid !== 1'b0) begin errors++; $display("FAIL t1_early_disp got %0d want 0", dispense_valid); end
    step();
    checks++; if (dispense_valid !== 1'b1) begin errors++; $display("FAIL t1_disp_valid got %0d want 1", dispense_valid); end
    checks++; if (dispense_id !== 10'd3) begin errors++; $display("FAIL t1_disp_id got %0d want 3", dispense_id); end
    checks++; if (cfg_item_update_req !== 1'b1) begin errors++; $display("FAIL t1_update_req got %0d want 1", cfg_item_update_req); end
    step();
    checks++; if (dispense_valid !== 1'b0) begin errors++; $display("FAIL t1_disp_pulse got %0d want 0", dispense_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (change_valid !== 1'b1 || change_value !== 16'd50) begin errors++; $display("FAIL t1_change_hold cyc %0d got %0d/%0d want 1/50", i, change_valid, change_value); end
      step();
    end
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL t1_change_done got %0d want 0", change_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy got %0d want 0", busy); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL t1_update_count got %0d want 1", upd_cnt - u0); end
    checks++; if (disp_cnt - d0 !== 1) begin errors++; $display("FAIL t1_disp_count got %0d want 1", disp_cnt - d0); end
  endtask

  task automatic test_errors();
    select(10'd8);
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd0) begin errors++; $display("FAIL t2_bad_id got %0d/%0d want 1/0", err_valid, err_code); end
    checks++; if (cfg_item_read_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t2_bad_id_idle got rr=%0d busy=%0d want 0/0", cfg_item_read_req, busy); end
    step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL t2_err_pulse got %0d want 0", err_valid); end
    select(10'd2);
    checks++; if (cfg_item_read_req !== 1'b1) begin errors++; $display("FAIL t2_sold_read got %0d want 1", cfg_item_read_req); end
    step();
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL t2_sold_out got %0d/%0d want 1/1", err_valid, err_code); end
    checks++; if (busy !== 1'b0 || coin_ready !== 1'b0) begin errors++; $display("FAIL t2_sold_idle got busy=%0d cr=%0d want 0/0", busy, coin_ready); end
    step();
    checks++; if (err_valid !== 1'b0 || coin_ready !== 1'b0) begin errors++; $display("FAIL t2_after got ev=%0d cr=%0d want 0/0", err_valid, coin_ready); end
  endtask

  task automatic test_cancel();
    int u0, d0;
    u0 = upd_cnt; d0 = disp_cnt;
    select(10'd4);
    step();
    coin_value = 16'd50; coin_valid = 1'b1;
    step();
    coin_value = 16'd25; cancel = 1'b1;
    step();
    coin_valid = 1'b0; cancel = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_value !== 16'd75) begin errors++; $display("FAIL t3_refund got %0d/%0d want 1/75", change_valid, change_value); end
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_busy got %0d want 0", busy); end
    checks++; if (disp_cnt - d0 !== 0 || upd_cnt - u0 !== 0) begin errors++; $display("FAIL t3_no_dispense got d=%0d u=%0d want 0/0", disp_cnt - d0, upd_cnt - u0); end
    // cancel with nothing inserted goes straight to idle
    select(10'd4);
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL t3_zero_refund got busy=%0d cv=%0d want 0/0", busy, change_valid); end
  endtask

  task automatic test_timeout();
    select(10'd1);
    step();
    coin_value = 16'd10; coin_valid = 1'b1;
    step();
    coin_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      checks++; if (err_valid !== 1'b0 || coin_ready !== 1'b1) begin errors++; $display("FAIL t4_early cyc %0d got ev=%0d cr=%0d want 0/1", i, err_valid, coin_ready); end
    end
    step();
    checks++; if (err_valid !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL t4_timeout got %0d/%0d want 1/2", err_valid, err_code); end
    checks++; if (change_valid !== 1'b1 || change_value !== 16'd10) begin errors++; $display("FAIL t4_refund got %0d/%0d want 1/10", change_valid, change_value); end
    step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got %0d want 0", err_valid); end
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
  endtask

  task automatic test_saturation();
    select(10'd5);
    step();
    coin_value = 16'hFFF0; coin_valid = 1'b1;
    step();
    coin_value = 16'h0100;
    step();
    coin_valid = 1'b0;
    checks++; if (dispense_valid !== 1'b1 || dispense_id !== 10'd5) begin errors++; $display("FAIL t5_disp got %0d/%0d want 1/5", dispense_valid, dispense_id); end
    step();
    checks++; if (change_valid !== 1'b1 || change_value !== 16'hFF9B) begin errors++; $display("FAIL t5_change got %0d/%0h want 1/ff9b", change_valid, change_value); end
    coin_value = 16'd5; coin_valid = 1'b1;
    step();
    coin_valid = 1'b0;
    checks++; if (change_value !== 16'hFF9B || coin_ready !== 1'b0) begin errors++; $display("FAIL t5_coin_in_change got %0h cr=%0d want ff9b/0", change_value, coin_ready); end
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %0d want 0", busy); end
    // balance must start from zero on the next transaction
    select(10'd5);
    step();
    coin_value = 16'd10; coin_valid = 1'b1; cancel = 1'b1;
    step();
    coin_valid = 1'b0; cancel = 1'b0;
    checks++; if (change_value !== 16'd10) begin errors++; $display("FAIL t5_balance_cleared got %0d want 10", change_value); end
    change_ack = 1'b1;
    step();
    change_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int u0;
    select(10'd5);
    step();
    coin_value = 16'd40; coin_valid = 1'b1;
    step();
    coin_valid = 1'b0;
    checks++; if (coin_ready !== 1'b1) begin errors++; $display("FAIL t6_in_collect got %0d want 1", coin_ready); end
    prst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || coin_ready !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL t6_async got busy=%0d cr=%0d cv=%0d want 0/0/0", busy, coin_ready, change_valid); end
    checks++; if (cfg_item_id !== 10'd0 || dispense_id !== 10'd0 || err_code !== 2'd0 || change_value !== 16'd0) begin errors++; $display("FAIL t6_async_regs got id=%0d did=%0d ec=%0d chg=%0d want 0/0/0/0", cfg_item_id, dispense_id, err_code, change_value); end
    step(); step();
    prst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (change_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_no_refund cyc %0d got cv=%0d busy=%0d want 0/0", i, change_valid, busy); end
    end
    u0 = upd_cnt;
    cfg_mode = 1'b1;
    select(10'd3);
    checks++; if (cfg_item_read_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_cfg_mode got rr=%0d busy=%0d want 0/0", cfg_item_read_req, busy); end
    step();
    checks++; if (cfg_item_read_req !== 1'b0 || upd_cnt != u0) begin errors++; $display("FAIL t6_cfg_mode2 got rr=%0d upd=%0d want 0/0", cfg_item_read_req, upd_cnt - u0); end
    cfg_mode = 1'b0;
  endtask

  initial begin
    prst = 1'b1; cfg_mode = 1'b0; num_items = 10'd8;
    sel_valid = 1'b0; sel_id = 10'd0; coin_valid = 1'b0; coin_value = 16'd0;
    cancel = 1'b0; change_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cost_mem[i] = 16'd0; avail_mem[i] = 8'd0;
    end
    cost_mem[1] = 16'd50;  avail_mem[1] = 8'd2;
    cost_mem[2] = 16'd80;  avail_mem[2] = 8'd0;
    cost_mem[3] = 16'd150; avail_mem[3] = 8'd5;
    cost_mem[4] = 16'd200; avail_mem[4] = 8'd1;
    cost_mem[5] = 16'd100; avail_mem[5] = 8'd3;

    test_reset();
    test_purchase();
    test_errors();
    test_cancel();
    test_timeout();
    test_saturation();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
